// File: rtl/sparc_exu_yreg_file_if.sv
// Y register file port bundle: W/G-stage update sources, E-stage read and status.
// The master drives updates and read select; the slave is the register file.
interface sparc_exu_yreg_file_if #(
  parameter int unsigned NTHR = 4,
  parameter int unsigned DW   = 32
) ();
  logic [NTHR-1:0] yreg_wen_w;
  logic [DW-1:0]   yreg_data_w;
  logic [NTHR-1:0] yreg_wen_g;
  logic [DW-1:0]   yreg_data_g;
  logic [NTHR-1:0] yreg_shift_g;
  logic            yreg_shift_in_g;
  logic [NTHR-1:0] yreg_rd_thr_e;
  logic [DW-1:0]   yreg_rd_data_e;
  logic [NTHR-1:0] yreg_lsb_l;
  logic [NTHR-1:0] yreg_wr_pend;
  logic            yreg_collide;

  modport master (
    output yreg_wen_w, yreg_data_w, yreg_wen_g, yreg_data_g,
           yreg_shift_g, yreg_shift_in_g, yreg_rd_thr_e,
    input  yreg_rd_data_e, yreg_lsb_l, yreg_wr_pend, yreg_collide
  );

  modport slave (
    input  yreg_wen_w, yreg_data_w, yreg_wen_g, yreg_data_g,
           yreg_shift_g, yreg_shift_in_g, yreg_rd_thr_e,
    output yreg_rd_data_e, yreg_lsb_l, yreg_wr_pend, yreg_collide
  );
endinterface

// File: rtl/sparc_exu_yreg_file.sv
// Per-thread Y register file: staged W write, G-stage write and MULScc shift,
// optional W-stage read bypass, pending-write status and collision pulse.
module sparc_exu_yreg_file #(
  parameter int unsigned    NTHR    = 4,
  parameter int unsigned    DW      = 32,
  parameter bit             BYPASS  = 1'b1,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input logic                  clk,
  input logic                  rst_l,
  sparc_exu_yreg_file_if.slave yif
);

  logic [DW-1:0]   r_y [NTHR];
  logic [DW-1:0]   w_y_nxt [NTHR];
  logic [DW-1:0]   r_stage_data;
  logic [NTHR-1:0] r_stage_vld;
  logic            r_collide;
  logic            w_collide;
  logic [DW-1:0]   w_rd_data;
  logic [NTHR-1:0] w_lsb_l;

  // Priority per thread: staged W commit, then G write, then shift.
  always_comb begin
    w_collide = 1'b0;
    for (int unsigned t = 0; t < NTHR; t++) begin
      w_y_nxt[t] = r_y[t];
      if (r_stage_vld[t])
        w_y_nxt[t] = r_stage_data;
      else if (yif.yreg_wen_g[t])
        w_y_nxt[t] = yif.yreg_data_g;
      else if (yif.yreg_shift_g[t])
        w_y_nxt[t] = {yif.yreg_shift_in_g, r_y[t][DW-1:1]};
      if ((r_stage_vld[t] & yif.yreg_wen_g[t]) |
          (r_stage_vld[t] & yif.yreg_shift_g[t]) |
          (yif.yreg_wen_g[t] & yif.yreg_shift_g[t]))
        w_collide = 1'b1;
    end
    if ($countones(yif.yreg_wen_w) > 1)
      w_collide = 1'b1;
    if ($countones(yif.yreg_rd_thr_e) > 1)
      w_collide = 1'b1;
  end

  // A single-thread file ignores the select and always presents register 0.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned t = 0; t < NTHR; t++) begin
      w_lsb_l[t] = ~r_y[t][0];
      if (yif.yreg_rd_thr_e[t] || (NTHR == 1))
        w_rd_data = w_rd_data | ((BYPASS && r_stage_vld[t]) ? r_stage_data : r_y[t]);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned t = 0; t < NTHR; t++)
        r_y[t] <= RST_VAL;
      r_stage_data <= '0;
      r_stage_vld  <= '0;
      r_collide    <= 1'b0;
    end else begin
      for (int unsigned t = 0; t < NTHR; t++)
        r_y[t] <= w_y_nxt[t];
      r_stage_data <= yif.yreg_data_w;
      r_stage_vld  <= yif.yreg_wen_w;
      r_collide    <= w_collide;
    end
  end

  assign yif.yreg_rd_data_e = w_rd_data;
  assign yif.yreg_lsb_l     = w_lsb_l;
  assign yif.yreg_wr_pend   = r_stage_vld;
  assign yif.yreg_collide   = r_collide;

endmodule

// File: tb/tb_sparc_exu_yreg_file.sv
// Bench for sparc_exu_yreg_file: 4x32 bypass instance checked against a
// reference model through a scoreboard, plus directed checks on an 8x64 no-bypass instance.
module tb_sparc_exu_yreg_file;

  localparam logic [63:0] RST_B = 64'h0123_4567_89AB_CDEF;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sparc_exu_yreg_file_if #(.NTHR(4), .DW(32)) ifa ();
  sparc_exu_yreg_file_if #(.NTHR(8), .DW(64)) ifb ();

  sparc_exu_yreg_file #(.NTHR(4), .DW(32), .BYPASS(1'b1), .RST_VAL(32'h0)) u_dut_a (
    .clk(clk), .rst_l(rst_l), .yif(ifa));
  sparc_exu_yreg_file #(.NTHR(8), .DW(64), .BYPASS(1'b0), .RST_VAL(RST_B)) u_dut_b (
    .clk(clk), .rst_l(rst_l), .yif(ifb));

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  lsb_l;
    logic [3:0]  pend;
    logic        col;
  } exp_t;

  exp_t        sb[$];
  exp_t        s_e;
  logic [31:0] m_y [4];
  logic [31:0] m_sd;
  logic [3:0]  m_sv;
  logic        m_col;
  logic [3:0]  r_ww, r_rr, r_gg, r_ss;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) m_y[t] = '0;
    m_sd  = '0;
    m_sv  = '0;
    m_col = 1'b0;
  endtask

  // Drive one cycle on instance A; push what it must show this cycle, then advance the model.
  task automatic step(input logic [3:0] wen_w, input logic [31:0] dw,
                      input logic [3:0] wen_g, input logic [31:0] dg,
                      input logic [3:0] sh, input logic shin, input logic [3:0] rd);
    exp_t e;
    logic bad;
    @(negedge clk);
    ifa.yreg_wen_w      = wen_w;
    ifa.yreg_data_w     = dw;
    ifa.yreg_wen_g      = wen_g;
    ifa.yreg_data_g     = dg;
    ifa.yreg_shift_g    = sh;
    ifa.yreg_shift_in_g = shin;
    ifa.yreg_rd_thr_e   = rd;
    e.rd = '0;
    for (int t = 0; t < 4; t++) begin
      if (rd[t]) e.rd = e.rd | (m_sv[t] ? m_sd : m_y[t]);
      e.lsb_l[t] = ~m_y[t][0];
    end
    e.pend = m_sv;
    e.col  = m_col;
    sb.push_back(e);
    bad = ($countones(wen_w) > 1) || ($countones(rd) > 1);
    for (int t = 0; t < 4; t++) begin
      if ((int'(m_sv[t]) + int'(wen_g[t]) + int'(sh[t])) > 1) bad = 1'b1;
      if (m_sv[t])       m_y[t] = m_sd;
      else if (wen_g[t]) m_y[t] = dg;
      else if (sh[t])    m_y[t] = {shin, m_y[t][31:1]};
    end
    m_sd  = dw;
    m_sv  = wen_w;
    m_col = bad;
  endtask

  task automatic peek(input string tag, input logic [3:0] rd, input logic [31:0] exp);
    step('0, '0, '0, '0, '0, 1'b0, rd);
    #3 check(tag, ifa.yreg_rd_data_e, exp);
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      s_e = sb.pop_front();
      check("sb_rd",   ifa.yreg_rd_data_e, s_e.rd);
      check("sb_lsbl", ifa.yreg_lsb_l,     s_e.lsb_l);
      check("sb_pend", ifa.yreg_wr_pend,   s_e.pend);
      check("sb_col",  ifa.yreg_collide,   s_e.col);
    end
  end

  initial begin
    ifa.yreg_wen_w = '0; ifa.yreg_data_w = '0; ifa.yreg_wen_g = '0; ifa.yreg_data_g = '0;
    ifa.yreg_shift_g = '0; ifa.yreg_shift_in_g = 1'b0; ifa.yreg_rd_thr_e = '0;
    ifb.yreg_wen_w = '0; ifb.yreg_data_w = '0; ifb.yreg_wen_g = '0; ifb.yreg_data_g = '0;
    ifb.yreg_shift_g = '0; ifb.yreg_shift_in_g = 1'b0; ifb.yreg_rd_thr_e = 8'h80;
    model_reset();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;

    // Reset state
    for (int t = 0; t < 4; t++) peek("rst_rd", 4'(1 << t), 32'h0);
    check("rst_lsbl", ifa.yreg_lsb_l, 4'hF);
    check("rst_pend", ifa.yreg_wr_pend, 4'h0);
    check("b_rst_rd", ifb.yreg_rd_data_e, RST_B);
    check("b_rst_lsbl", ifb.yreg_lsb_l, 8'h00);

    // Reset while a W write is staged
    step(4'b0001, 32'hCAFE_F00D, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    ifa.yreg_wen_w = '0;
    ifa.yreg_rd_thr_e = 4'b0001;
    #3;
    check("mid_pend", ifa.yreg_wr_pend, 4'b0001);
    check("mid_byp", ifa.yreg_rd_data_e, 32'hCAFE_F00D);
    rst_l = 1'b0;
    #1;
    check("mid_rst_pend", ifa.yreg_wr_pend, 4'b0000);
    @(negedge clk);
    rst_l = 1'b1;
    model_reset();
    peek("mid_lost", 4'b0001, 32'h0);

    // W write latency and bypass
    step(4'b0010, 32'hDEAD_BEEF, '0, '0, '0, 1'b0, '0);
    peek("w_byp", 4'b0010, 32'hDEAD_BEEF);
    check("w_pend1", ifa.yreg_wr_pend, 4'b0010);
    peek("w_commit", 4'b0010, 32'hDEAD_BEEF);
    check("w_pend2", ifa.yreg_wr_pend, 4'b0000);

    // MULScc shifts
    step(4'b0001, 32'h0000_0003, '0, '0, '0, 1'b0, '0);
    step('0, '0, '0, '0, '0, 1'b0, '0);
    step('0, '0, '0, '0, 4'b0001, 1'b1, '0);
    peek("shift1", 4'b0001, 32'h8000_0001);
    check("shift1_lsbl", ifa.yreg_lsb_l[0], 1'b0);
    for (int i = 0; i < 32; i++) step('0, '0, '0, '0, 4'b0001, 1'b0, '0);
    peek("shift32", 4'b0001, 32'h0);
    check("shift32_lsbl", ifa.yreg_lsb_l[0], 1'b1);

    // Stage commit collides with G write on thread 2
    step(4'b0100, 32'h1111_1111, '0, '0, '0, 1'b0, '0);
    step('0, '0, 4'b0100, 32'h2222_2222, '0, 1'b0, '0);
    peek("coll_rd", 4'b0100, 32'h1111_1111);
    check("coll_pulse", ifa.yreg_collide, 1'b1);
    peek("coll_rd2", 4'b0100, 32'h1111_1111);
    check("coll_clear", ifa.yreg_collide, 1'b0);

    // Independent updates on three threads in one cycle
    step(4'b0010, 32'h1234_5678, '0, '0, '0, 1'b0, '0);
    step('0, '0, 4'b1000, 32'hA5A5_A5A5, 4'b0001, 1'b1, '0);
    peek("par_t3", 4'b1000, 32'hA5A5_A5A5);
    check("par_nocoll", ifa.yreg_collide, 1'b0);
    peek("par_t0", 4'b0001, 32'h8000_0000);
    peek("par_t1", 4'b0010, 32'h1234_5678);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      r_ww = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      r_rr = ($urandom_range(0, 4) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      r_gg = 4'($urandom) & 4'($urandom);
      r_ss = 4'($urandom) & 4'($urandom);
      step(r_ww, $urandom, r_gg, $urandom, r_ss, 1'($urandom), r_rr);
    end
    step('0, '0, '0, '0, '0, 1'b0, '0);
    step('0, '0, '0, '0, '0, 1'b0, '0);

    // 8-thread 64-bit instance without bypass
    @(negedge clk);
    ifb.yreg_wen_w  = 8'h80;
    ifb.yreg_data_w = 64'hFFFF_0000_1234_5678;
    ifb.yreg_rd_thr_e = 8'h80;
    @(negedge clk);
    ifb.yreg_wen_w = '0;
    #3;
    check("b_nobyp", ifb.yreg_rd_data_e, RST_B);
    check("b_pend", ifb.yreg_wr_pend, 8'h80);
    @(negedge clk);
    #3;
    check("b_commit", ifb.yreg_rd_data_e, 64'hFFFF_0000_1234_5678);
    check("b_pend0", ifb.yreg_wr_pend, 8'h00);
    check("b_lsbl", ifb.yreg_lsb_l, 8'h80);
    @(negedge clk);
    ifb.yreg_rd_thr_e = 8'h81;
    #3 check("b_precoll", ifb.yreg_collide, 1'b0);
    @(negedge clk);
    ifb.yreg_rd_thr_e = 8'h01;
    ifb.yreg_shift_g = 8'h01;
    ifb.yreg_shift_in_g = 1'b1;
    #3;
    check("b_coll", ifb.yreg_collide, 1'b1);
    check("b_rd0", ifb.yreg_rd_data_e, RST_B);
    @(negedge clk);
    ifb.yreg_shift_g = '0;
    #3;
    check("b_coll_clear", ifb.yreg_collide, 1'b0);
    check("b_shift", ifb.yreg_rd_data_e, 64'h8091_A2B3_C4D5_E6F7);

    repeat (2) @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
